alu_shift_sequencer: RTL

ALU_SHIFT_SEQUENCER -- requirements
Module: alu_shift_sequencer

---
 rtl/alu_shift_sequencer_if.sv | 32 +++
 rtl/alu_shift_sequencer.sv | 133 +++++++++++++
 2 files changed

// File: rtl/alu_shift_sequencer_if.sv
// Request, ALU and response signal bundle for the shift sequencer.
interface alu_shift_sequencer_if;
  logic        ReqValid;
  logic        ReqReady;
  logic [1:0]  ReqOp;
  logic        ReqWide;
  logic [4:0]  ReqAmount;
  logic [31:0] ReqOperand;
  logic [31:0] AluA;
  logic [4:0]  AluFunSel;
  logic        AluWF;
  logic [31:0] AluOut;
  logic [3:0]  AluFlags;
  logic        RespValid;
  logic        RespReady;
  logic [31:0] RespResult;
  logic [3:0]  RespFlags;

  // Requester / ALU / consumer side.
  modport master (
    output ReqValid, ReqOp, ReqWide, ReqAmount, ReqOperand,
    output AluOut, AluFlags, RespReady,
    input  ReqReady, AluA, AluFunSel, AluWF, RespValid, RespResult, RespFlags
  );

  // Sequencer side.
  modport slave (
    input  ReqValid, ReqOp, ReqWide, ReqAmount, ReqOperand,
    input  AluOut, AluFlags, RespReady,
    output ReqReady, AluA, AluFunSel, AluWF, RespValid, RespResult, RespFlags
  );
endinterface

// File: rtl/alu_shift_sequencer.sv
// Multi-cycle shifter: issues one single-bit shift per step to an external
// registered ALU and accumulates the result until the count reaches zero.
module alu_shift_sequencer (
  input  logic                  Clock,
  input  logic                  Reset,
  alu_shift_sequencer_if.slave  bus
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned SEL_W  = 5;
  localparam int unsigned FLG_W  = 4;

  localparam logic [SEL_W-1:0] FUN_PASS_A = 5'b10000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t              state_q;
  logic [DATA_W-1:0]   acc_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic [1:0]          op_q;
  logic                wide_q;
  logic                req_ready_q;
  logic [DATA_W-1:0]   alu_a_q;
  logic [SEL_W-1:0]    alu_fun_sel_q;
  logic                alu_wf_q;
  logic                resp_valid_q;
  logic [FLG_W-1:0]    resp_flags_q;

  // ALU function select for one single-bit step of the requested shift.
  function automatic logic [SEL_W-1:0] fun_sel(input logic wide, input logic [1:0] op);
    logic [3:0] code;
    case (op)
      2'b00:   code = 4'b1011;
      2'b01:   code = 4'b1100;
      2'b10:   code = 4'b1101;
      default: code = 4'b1110;
    endcase
    return {wide, code};
  endfunction

  // Remaining count after the step currently returning from the ALU.
  always_comb begin
    cnt_d = cnt_q - CNT_W'(1);
  end

  // Sequencer FSM with all outputs registered alongside the state.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q       <= S_IDLE;
      acc_q         <= '0;
      cnt_q         <= '0;
      op_q          <= '0;
      wide_q        <= 1'b0;
      req_ready_q   <= 1'b0;
      alu_a_q       <= '0;
      alu_fun_sel_q <= FUN_PASS_A;
      alu_wf_q      <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_flags_q  <= '0;
    end else begin
      alu_a_q       <= '0;
      alu_fun_sel_q <= FUN_PASS_A;
      alu_wf_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          req_ready_q <= 1'b1;
          if (bus.ReqValid && req_ready_q) begin
            req_ready_q <= 1'b0;
            op_q        <= bus.ReqOp;
            wide_q      <= bus.ReqWide;
            acc_q       <= bus.ReqOperand;
            cnt_q       <= bus.ReqAmount;
            if (bus.ReqAmount == '0) begin
              state_q      <= S_DONE;
              resp_valid_q <= 1'b1;
              resp_flags_q <= '0;
            end else begin
              state_q       <= S_ISSUE;
              alu_a_q       <= bus.ReqOperand;
              alu_fun_sel_q <= fun_sel(bus.ReqWide, bus.ReqOp);
              alu_wf_q      <= (bus.ReqAmount == CNT_W'(1));
            end
          end
        end
        S_ISSUE: begin
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          acc_q <= bus.AluOut;
          cnt_q <= cnt_d;
          if (cnt_d == '0) begin
            state_q      <= S_DONE;
            resp_valid_q <= 1'b1;
            resp_flags_q <= bus.AluFlags;
          end else begin
            state_q       <= S_ISSUE;
            alu_a_q       <= bus.AluOut;
            alu_fun_sel_q <= fun_sel(wide_q, op_q);
            alu_wf_q      <= (cnt_d == CNT_W'(1));
          end
        end
        S_DONE: begin
          // Ready rises here so the next request lands one edge later.
          if (bus.RespReady) begin
            state_q      <= S_IDLE;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // The accumulator holds still in DONE, so it doubles as the result.
  assign bus.ReqReady   = req_ready_q;
  assign bus.AluA       = alu_a_q;
  assign bus.AluFunSel  = alu_fun_sel_q;
  assign bus.AluWF      = alu_wf_q;
  assign bus.RespValid  = resp_valid_q;
  assign bus.RespResult = acc_q;
  assign bus.RespFlags  = resp_flags_q;

endmodule
